// File: rtl/clk_divider_pkg.sv
// Shared types, limits and the divisor clamp for the clock divider bank.
// div_t is sized for the widest supported counter (W <= 32); channels narrow it back to W.
package clk_divider_pkg;

  localparam int DIV_W_MAX = 32;

  typedef logic [DIV_W_MAX-1:0] div_t;

  typedef struct packed {
    div_t div;
    div_t duty;
  } chan_cfg_t;

  localparam div_t DIV_MIN = div_t'(2);

  function automatic div_t clamp_div(input div_t d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_divider_chan.sv
// One divider channel: counter, shadowed divisor (and duty with CLK_DIVIDER_BANK_DUTY_EN),
// registered square output, end-of-period tick and pending flag.
module clk_divider_chan
  import clk_divider_pkg::*;
#(
  parameter int           W           = 28,
  parameter logic [W-1:0] DEFAULT_DIV = W'(100_000)
) (
  input  logic         i_CLK,
  input  logic         i_RST_N,
  input  logic         i_en,
  input  logic         i_sync,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_div,
`ifdef CLK_DIVIDER_BANK_DUTY_EN
  input  logic [W-1:0] i_wr_duty,
`endif
  output logic         o_clk,
  output logic         o_tick,
  output logic         o_pend
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] sh_div_q, sh_div_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic [W-1:0] hi;
  logic [W-1:0] wr_div_c;
  logic         wrap;

  assign wr_div_c = W'(clamp_div(div_t'(i_wr_div)));
  assign wrap     = i_en && (cnt_q == div_q - W'(1));

`ifdef CLK_DIVIDER_BANK_DUTY_EN
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] sh_duty_q, sh_duty_d;
  assign hi = duty_q;
`else
  assign hi = div_q >> 1;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    sh_div_d = sh_div_q;
    pend_d   = pend_q;
    clk_d    = 1'b0;
    tick_d   = 1'b0;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
    duty_d    = duty_q;
    sh_duty_d = sh_duty_q;
`endif
    if (i_sync) begin
      // Sync restarts at phase 0; a same-edge write bypasses the shadow.
      cnt_d  = '0;
      pend_d = 1'b0;
      if (i_wr) begin
        div_d    = wr_div_c;
        sh_div_d = wr_div_c;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
        duty_d    = i_wr_duty;
        sh_duty_d = i_wr_duty;
`endif
      end else if (pend_q) begin
        div_d = sh_div_q;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
        duty_d = sh_duty_q;
`endif
      end
    end else begin
      if (i_en) begin
        clk_d  = (cnt_q < hi);
        tick_d = wrap;
        cnt_d  = wrap ? '0 : cnt_q + W'(1);
      end else begin
        cnt_d = '0;
      end
      // Apply before accepting a new write so a same-edge write waits for the next wrap.
      if (pend_q && (wrap || !i_en)) begin
        div_d  = sh_div_q;
        pend_d = 1'b0;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
        duty_d = sh_duty_q;
`endif
      end
      if (i_wr) begin
        sh_div_d = wr_div_c;
        pend_d   = 1'b1;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
        sh_duty_d = i_wr_duty;
`endif
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q    <= '0;
      div_q    <= DEFAULT_DIV;
      sh_div_q <= DEFAULT_DIV;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
      duty_q    <= DEFAULT_DIV >> 1;
      sh_duty_q <= DEFAULT_DIV >> 1;
`endif
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sh_div_q <= sh_div_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
`ifdef CLK_DIVIDER_BANK_DUTY_EN
      duty_q    <= duty_d;
      sh_duty_q <= sh_duty_d;
`endif
    end
  end

  assign o_clk  = clk_q;
  assign o_tick = tick_q;
  assign o_pend = pend_q;

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of N_CH runtime-programmable clock dividers with a shared phase-align sync.
// Define CLK_DIVIDER_BANK_DUTY_EN to add a programmable, shadowed high time (i_wr_duty).
module clk_divider_bank
  import clk_divider_pkg::*;
#(
  parameter int           N_CH        = 4,
  parameter int           W           = 28,
  parameter logic [W-1:0] DEFAULT_DIV = W'(100_000),
  localparam int          CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  input  logic [N_CH-1:0] i_en,
  input  logic            i_sync,
  input  logic            i_wr_en,
  input  logic [CH_W-1:0] i_wr_ch,
  input  logic [W-1:0]    i_wr_div,
`ifdef CLK_DIVIDER_BANK_DUTY_EN
  input  logic [W-1:0]    i_wr_duty,
`endif
  output logic [N_CH-1:0] o_clk,
  output logic [N_CH-1:0] o_tick,
  output logic [N_CH-1:0] o_pend
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr_g;
    // Indices >= N_CH match no channel, so such writes are dropped.
    assign wr_g = i_wr_en && (i_wr_ch == CH_W'(g));

    clk_divider_chan #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .i_CLK     (i_CLK),
      .i_RST_N   (i_RST_N),
      .i_en      (i_en[g]),
      .i_sync    (i_sync),
      .i_wr      (wr_g),
      .i_wr_div  (i_wr_div),
`ifdef CLK_DIVIDER_BANK_DUTY_EN
      .i_wr_duty (i_wr_duty),
`endif
      .o_clk     (o_clk[g]),
      .o_tick    (o_tick[g]),
      .o_pend    (o_pend[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a period-level reference model.
module tb_clk_divider_bank;

  localparam int N_CH = 5;
  localparam int W    = 28;
  localparam int CH_W = 3;

  logic            clk, rst_n, sync, wr_en;
  logic [N_CH-1:0] en;
  logic [CH_W-1:0] wr_ch;
  logic [W-1:0]    wr_div, wr_duty;
  logic [N_CH-1:0] o_clk, o_tick, o_pend;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  clk_divider_bank #(.N_CH(N_CH), .W(W), .DEFAULT_DIV(W'(10))) dut (
    .i_CLK     (clk),
    .i_RST_N   (rst_n),
    .i_en      (en),
    .i_sync    (sync),
    .i_wr_en   (wr_en),
    .i_wr_ch   (wr_ch),
    .i_wr_div  (wr_div),
`ifdef CLK_DIVIDER_BANK_DUTY_EN
    .i_wr_duty (wr_duty),
`endif
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pend    (o_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase within the current period plus active/shadow settings.
  int unsigned m_ph[N_CH], m_div[N_CH], m_sh[N_CH], m_duty[N_CH], m_shduty[N_CH];
  bit          m_pend[N_CH];
  logic [N_CH-1:0] exp_clk, exp_tick, exp_pend;

  function automatic int unsigned high_time(input int c);
`ifdef CLK_DIVIDER_BANK_DUTY_EN
    return m_duty[c];
`else
    return m_div[c] / 2;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_ph[c] = 0; m_div[c] = 10; m_sh[c] = 10; m_duty[c] = 5; m_shduty[c] = 5; m_pend[c] = 0;
    end
    exp_clk = '0; exp_tick = '0; exp_pend = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      bit w, boundary;
      int unsigned nd;
      w  = wr_en && (int'(wr_ch) == c);
      nd = (wr_div < 2) ? 2 : int'(wr_div);
      boundary = 0;
      if (sync) begin
        m_ph[c] = 0; exp_clk[c] = 0; exp_tick[c] = 0;
        if (w) begin
          m_div[c] = nd; m_sh[c] = nd; m_duty[c] = int'(wr_duty); m_shduty[c] = int'(wr_duty);
        end else if (m_pend[c]) begin
          m_div[c] = m_sh[c]; m_duty[c] = m_shduty[c];
        end
        m_pend[c] = 0;
      end else begin
        if (en[c]) begin
          exp_clk[c]  = (m_ph[c] < high_time(c));
          exp_tick[c] = (m_ph[c] == m_div[c] - 1);
          boundary    = exp_tick[c];
          m_ph[c]     = boundary ? 0 : m_ph[c] + 1;
        end else begin
          exp_clk[c] = 0; exp_tick[c] = 0; m_ph[c] = 0; boundary = 1;
        end
        if (m_pend[c] && boundary) begin
          m_div[c] = m_sh[c]; m_duty[c] = m_shduty[c]; m_pend[c] = 0;
        end
        if (w) begin
          m_sh[c] = nd; m_shduty[c] = int'(wr_duty); m_pend[c] = 1;
        end
      end
      exp_pend[c] = m_pend[c];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_clk",  64'(o_clk),  64'(exp_clk));
        chk("model_tick", 64'(o_tick), 64'(exp_tick));
        chk("model_pend", 64'(o_pend), 64'(exp_pend));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic [N_CH-1:0] h_clk[64], h_tick[64], h_pend[64];

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      h_clk[k] = o_clk; h_tick[k] = o_tick; h_pend[k] = o_pend;
    end
  endtask

  function automatic logic [63:0] col(input int sel, input int ch, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      case (sel)
        0:       r[k] = h_clk[k][ch];
        1:       r[k] = h_tick[k][ch];
        default: r[k] = h_pend[k][ch];
      endcase
    end
    return r;
  endfunction

  task automatic wr(input int ch, input int div, input int duty);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = W'(div); wr_duty = W'(duty);
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_duty = '0;
    model_reset();
    chk_en = 1;
    repeat (3) cyc();
    chk("reset_clk",  64'(o_clk),  64'h0);
    chk("reset_tick", 64'(o_tick), 64'h0);
    chk("reset_pend", 64'(o_pend), 64'h0);

    // Default divisor 10 on channel 0: 5 high / 5 low, tick every 10.
    rst_n = 1'b1; en = 5'b00001;
    record(20);
    chk("d10_clk",  col(0, 0, 20), 64'h7C1F);
    chk("d10_tick", col(1, 0, 20), 64'h80200);

    // Retune channel 1 mid-period to 4.
    en = 5'b00011;
    repeat (3) cyc();
    wr(1, 4, 2);
    chk("retune_pend_set", 64'(o_pend[1]), 64'h1);
    record(14);
    chk("retune_clk",  col(0, 1, 14), 64'hCC1);
    chk("retune_tick", col(1, 1, 14), 64'h2220);
    chk("retune_pend", col(2, 1, 14), 64'h1F);

    // Divisors 0 and 1 clamp to 2; out-of-range channel is ignored.
    wr(2, 0, 1);
    chk("clamp_pend2", 64'(o_pend[2]), 64'h1);
    wr(3, 1, 1);
    wr(5, 7, 3);
    chk("bad_ch_pend", 64'(o_pend), 64'h0);
    en = 5'b01111;
    record(6);
    chk("div0_clk",  col(0, 2, 6), 64'h15);
    chk("div0_tick", col(1, 2, 6), 64'h2A);
    chk("div1_clk",  col(0, 3, 6), 64'h15);
    chk("div1_tick", col(1, 3, 6), 64'h2A);

    // Sync with one pending write and one write on the sync edge.
    wr(2, 6, 3);
    wr_en = 1'b1; wr_ch = 3'd3; wr_div = W'(9); wr_duty = W'(4); sync = 1'b1;
    cyc();
    wr_en = 1'b0; sync = 1'b0;
    chk("sync_clk",  64'(o_clk),  64'h0);
    chk("sync_tick", 64'(o_tick), 64'h0);
    chk("sync_pend", 64'(o_pend), 64'h0);
    record(18);
    chk("sync6_clk",  col(0, 2, 18), 64'h71C7);
    chk("sync6_tick", col(1, 2, 18), 64'h20820);
    chk("sync9_clk",  col(0, 3, 18), 64'h1E0F);
    chk("sync9_tick", col(1, 3, 18), 64'h20100);

    // Disable channel 2, retune to 3 while idle, re-enable.
    en = 5'b01011;
    cyc();
    chk("dis_clk", 64'(o_clk[2]), 64'h0);
    wr(2, 3, 1);
    chk("dis_pend_set", 64'(o_pend[2]), 64'h1);
    cyc();
    chk("dis_pend_clr", 64'(o_pend[2]), 64'h0);
    en = 5'b01111;
    record(6);
    chk("div3_clk",  col(0, 2, 6), 64'h9);
    chk("div3_tick", col(1, 2, 6), 64'h24);

    // Asynchronous reset mid-period.
    wr(0, 7, 3);
    chk("pre_rst_pend", 64'(o_pend[0]), 64'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_clk",  64'(o_clk),  64'h0);
    chk("async_rst_tick", 64'(o_tick), 64'h0);
    chk("async_rst_pend", 64'(o_pend), 64'h0);
    repeat (2) cyc();
    rst_n = 1'b1;

`ifdef CLK_DIVIDER_BANK_DUTY_EN
    begin
      int          duties[3] = '{2, 0, 8};
      logic [63:0] exps[3]   = '{64'h0303, 64'h0, 64'hFFFF};
      for (int i = 0; i < 3; i++) begin
        en[4] = 1'b0;
        wr(4, 8, duties[i]);
        cyc();
        en[4] = 1'b1;
        record(16);
        chk("duty_clk",  col(0, 4, 16), exps[i]);
        chk("duty_tick", col(1, 4, 16), 64'h8080);
      end
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
      sync    = ($urandom_range(0, 99) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_ch   = CH_W'($urandom_range(0, 7));
      wr_div  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(3, 13));
      wr_duty = W'($urandom_range(0, 15));
      cyc();
    end
    sync = 1'b0; wr_en = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
